// File: rtl/debounce_pkg.sv
// Shared definitions for the two-channel button debouncer:
// channel FSM state encoding and the default stable-time count.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } state_t;

   // 10 ms at 50 MHz
   localparam int unsigned DEFAULT_CNT_MAX = 500000;

endpackage

// File: rtl/button_debounce_pair_if.sv
// Raw-pin and conditioned-level signals of the debouncer front end.
// The master drives the raw pins; the slave is the debouncer.
interface button_debounce_pair_if;

   logic btn_a_raw;
   logic btn_b_raw;
   logic a_o;
   logic b_o;
   logic a_rise_o;
   logic b_rise_o;

   modport master (
      output btn_a_raw, btn_b_raw,
      input  a_o, b_o, a_rise_o, b_rise_o
   );

   modport slave (
      input  btn_a_raw, btn_b_raw,
      output a_o, b_o, a_rise_o, b_rise_o
   );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: two-FF synchroniser, stable-time counter and
// a four-state FSM producing a registered level and a rising-edge pulse.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned CNT_MAX = DEFAULT_CNT_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
);

   localparam int unsigned     CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

   logic             s1;
   logic             s2;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             level_nxt;
   logic             rise_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw_i;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= STABLE_LO;
         cnt     <= '0;
         level_o <= 1'b0;
         rise_o  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         level_o <= level_nxt;
         rise_o  <= rise_nxt;
      end
   end

   // Any disagreement of s2 during a WAIT state drops back to STABLE,
   // so the next entry restarts the full window from zero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level_o;
      rise_nxt  = 1'b0;
      case (state)
         STABLE_LO: begin
            if (s2) begin
               state_nxt = WAIT_HI;
               cnt_nxt   = '0;
            end
         end
         WAIT_HI: begin
            if (!s2) begin
               state_nxt = STABLE_LO;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_HI;
               level_nxt = 1'b1;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            if (!s2) begin
               state_nxt = WAIT_LO;
               cnt_nxt   = '0;
            end
         end
         WAIT_LO: begin
            if (s2) begin
               state_nxt = STABLE_HI;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_LO;
               level_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = STABLE_LO;
      endcase
   end

endmodule

// File: rtl/button_debounce_pair.sv
// Front-end conditioning for the two-input gate: two independent
// debounce channels turning raw pins into clean a/b levels and rise pulses.
module button_debounce_pair
   import debounce_pkg::*;
#(
   parameter int unsigned CNT_MAX = DEFAULT_CNT_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_a_raw,
   input  logic btn_b_raw,
   output logic a_o,
   output logic b_o,
   output logic a_rise_o,
   output logic b_rise_o
);

   debounce_channel #(.CNT_MAX(CNT_MAX)) u_chan_a (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_a_raw),
      .level_o (a_o),
      .rise_o  (a_rise_o)
   );

   debounce_channel #(.CNT_MAX(CNT_MAX)) u_chan_b (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_b_raw),
      .level_o (b_o),
      .rise_o  (b_rise_o)
   );

endmodule

// File: tb/tb_button_debounce_pair.sv
// Self-checking bench for button_debounce_pair with CNT_MAX=8: a run-length
// reference model feeds a scoreboard, plus hand-written timing sequences and a segment table.
module tb_button_debounce_pair;

   localparam int unsigned CNT_MAX = 8;

   logic clk;
   logic rst;

   button_debounce_pair_if bus ();

   button_debounce_pair #(.CNT_MAX(CNT_MAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_a_raw (bus.btn_a_raw),
      .btn_b_raw (bus.btn_b_raw),
      .a_o       (bus.a_o),
      .b_o       (bus.b_o),
      .a_rise_o  (bus.a_rise_o),
      .b_rise_o  (bus.b_rise_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec  = 0;
   int unsigned n_fail = 0;

   // expected {a_o, b_o, a_rise_o, b_rise_o} after each driven edge
   logic [3:0] sb_q[$];

   // reference model: raw history and run length of disagreement with the level
   logic        m_d1[2];
   logic        m_d2[2];
   int unsigned m_run[2];
   logic        m_lvl[2];
   logic        m_rise[2];

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      check(name, {3'b000, act}, {3'b000, exp});
   endtask

   task automatic model_step(input logic r, input logic a, input logic b);
      logic raw;
      logic obs;
      for (int ch = 0; ch < 2; ch++) begin
         raw = (ch == 0) ? a : b;
         if (r) begin
            m_d1[ch]   = 1'b0;
            m_d2[ch]   = 1'b0;
            m_run[ch]  = 0;
            m_lvl[ch]  = 1'b0;
            m_rise[ch] = 1'b0;
         end else begin
            obs        = m_d2[ch];
            m_d2[ch]   = m_d1[ch];
            m_d1[ch]   = raw;
            m_rise[ch] = 1'b0;
            if (obs != m_lvl[ch]) begin
               m_run[ch]++;
               if (m_run[ch] == CNT_MAX + 1) begin
                  m_lvl[ch]  = obs;
                  m_rise[ch] = obs;
                  m_run[ch]  = 0;
               end
            end else begin
               m_run[ch] = 0;
            end
         end
      end
   endtask

   // Drive at a falling edge, let one rising edge happen, compare at the next falling edge.
   task automatic cycle(input logic r, input logic a, input logic b);
      logic [3:0] exp;
      rst           = r;
      bus.btn_a_raw = a;
      bus.btn_b_raw = b;
      model_step(r, a, b);
      sb_q.push_back({m_lvl[0], m_lvl[1], m_rise[0], m_rise[1]});
      @(posedge clk);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL sb_empty: got no entry expected one at %0t", $time);
      end else begin
         exp = sb_q.pop_front();
         check("sb", {bus.a_o, bus.b_o, bus.a_rise_o, bus.b_rise_o}, exp);
      end
   endtask

   typedef struct {
      logic        r;
      logic        a;
      logic        b;
      int unsigned n;
      logic        ea;
      logic        eb;
   } seg_t;

   seg_t tbl[13];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 2,  1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 12, 1'b1, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 5,  1'b1, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 11, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 8,  1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 12, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 9,  1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 12, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 11, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 1,  1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b0};

      for (int ch = 0; ch < 2; ch++) begin
         m_d1[ch] = 1'b0; m_d2[ch] = 1'b0; m_run[ch] = 0;
         m_lvl[ch] = 1'b0; m_rise[ch] = 1'b0;
      end
      rst = 1'b1;
      bus.btn_a_raw = 1'b1;
      bus.btn_b_raw = 1'b1;
      @(negedge clk);

      // reset held with both pins high
      for (int e = 1; e <= 3; e++) begin
         cycle(1'b1, 1'b1, 1'b1);
         check("t1_reset", {bus.a_o, bus.b_o, bus.a_rise_o, bus.b_rise_o}, 4'b0000);
      end
      for (int e = 1; e <= 12; e++) cycle(1'b0, 1'b0, 1'b0);

      // A rises and holds
      for (int e = 1; e <= 14; e++) begin
         cycle(1'b0, 1'b1, 1'b0);
         if (e == 10) chk1("t2_a_e10", bus.a_o, 1'b0);
         if (e == 11) begin
            chk1("t2_a_e11", bus.a_o, 1'b1);
            chk1("t2_rise_e11", bus.a_rise_o, 1'b1);
         end
         if (e == 12) begin
            chk1("t2_rise_e12", bus.a_rise_o, 1'b0);
            chk1("t2_a_e12", bus.a_o, 1'b1);
         end
      end

      // A falls and holds: no pulse, B untouched
      for (int e = 1; e <= 12; e++) begin
         cycle(1'b0, 1'b0, 1'b0);
         chk1("t4_no_rise", bus.a_rise_o, 1'b0);
         chk1("t4_b_idle", bus.b_o, 1'b0);
         if (e == 10) chk1("t4_a_e10", bus.a_o, 1'b1);
         if (e == 11) chk1("t4_a_e11", bus.a_o, 1'b0);
      end

      // A bounces 1,0,1,0 in 3-cycle steps, then holds high
      for (int e = 0; e < 12; e++) begin
         cycle(1'b0, ((e / 3) % 2) == 0, 1'b0);
         chk1("t3_bounce", bus.a_o, 1'b0);
      end
      for (int e = 1; e <= 12; e++) begin
         cycle(1'b0, 1'b1, 1'b0);
         if (e == 10) chk1("t3_a_e10", bus.a_o, 1'b0);
         if (e == 11) chk1("t3_a_e11", bus.a_o, 1'b1);
      end
      for (int e = 1; e <= 12; e++) cycle(1'b0, 1'b0, 1'b0);
      chk1("t3_a_low", bus.a_o, 1'b0);

      // A and B together, B glitches low on edge 5
      for (int e = 1; e <= 17; e++) begin
         cycle(1'b0, 1'b1, (e == 5) ? 1'b0 : 1'b1);
         if (e == 11) begin
            chk1("t5_a_e11", bus.a_o, 1'b1);
            chk1("t5_b_e11", bus.b_o, 1'b0);
         end
         if (e == 15) chk1("t5_b_e15", bus.b_o, 1'b0);
         if (e == 16) begin
            chk1("t5_b_e16", bus.b_o, 1'b1);
            chk1("t5_brise_e16", bus.b_rise_o, 1'b1);
         end
      end
      for (int e = 1; e <= 12; e++) cycle(1'b0, 1'b0, 1'b0);

      // reset in the middle of a debounce window
      for (int e = 1; e <= 5; e++) cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      chk1("t6_a_rst", bus.a_o, 1'b0);
      for (int e = 1; e <= 12; e++) begin
         cycle(1'b0, 1'b1, 1'b0);
         if (e == 10) chk1("t6_a_e10", bus.a_o, 1'b0);
         if (e == 11) begin
            chk1("t6_a_e11", bus.a_o, 1'b1);
            chk1("t6_rise_e11", bus.a_rise_o, 1'b1);
         end
      end

      // segment table: hold lengths around the acceptance boundary
      for (int s = 0; s < 13; s++) begin
         for (int unsigned k = 0; k < tbl[s].n; k++) cycle(tbl[s].r, tbl[s].a, tbl[s].b);
         check($sformatf("seg%0d", s), {2'b00, bus.a_o, bus.b_o}, {2'b00, tbl[s].ea, tbl[s].eb});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
